// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the RAM access controller.
//   ctrl_state_e : controller FSM states
//   DefAddrW     : default RAM address width
//   DefDataW     : default RAM word width
package ram_ctrl_pkg;

  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefDataW = 16;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StWr,
    StRd,
    StRdWait,
    StRsp
  } ctrl_state_e;

endpackage

// File: rtl/ram_access_ctrl.sv
// CPU-side access controller for a single-port block RAM.
// After reset it sweeps INIT_VAL into every location, then serves one
// store or load at a time. Load data is held on rsp_* until the CPU takes it.
//
// Ports
//   sys_clk                  : clock, everything on the rising edge
//   sys_rst_n                : synchronous reset, ACTIVE-HIGH despite the name
//   req_valid/req_ready      : request handshake (req_ready = state is idle)
//   req_we/req_addr/req_wdata: 1 = store, word address, store data
//   rsp_valid/rsp_ready      : load response handshake
//   rsp_rdata                : load data, stable while rsp_valid
//   wr_done                  : one-cycle pulse after a store is written
//   init_done                : level, high once the post-reset sweep finished
//   ram_en/ram_wea/ram_addr/ram_wr_data/ram_rd_data : block-RAM port
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefAddrW,
  parameter int unsigned       DATA_W   = DefDataW,
  parameter int unsigned       RD_LAT   = 1,  // legal range 1..3
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  output logic              init_done,
  output logic              ram_en,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam logic [1:0]    LatLast = 2'(RD_LAT - 1);
  localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

  ctrl_state_e       state_q, state_d;
  // One extra bit so the sweep end is seen as cnt_q[ADDR_W] instead of a wrap to 0.
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [1:0]        lat_q, lat_d;
  logic              init_done_q, init_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              wr_done_q, wr_done_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_wea_q, ram_wea_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;

  // RAM controls are computed from the state being entered, so ram_en is high
  // in the same cycle the FSM sits in WR/RD.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lat_d         = lat_q;
    init_done_d   = init_done_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    wr_done_d     = 1'b0;
    ram_en_d      = 1'b0;
    ram_wea_d     = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;

    case (state_q)
      StInit: begin
        if (cnt_q[ADDR_W]) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end else begin
          ram_en_d      = 1'b1;
          ram_wea_d     = 1'b1;
          ram_addr_d    = cnt_q[ADDR_W-1:0];
          ram_wr_data_d = INIT_VAL;
          cnt_d         = cnt_q + CntOne;
        end
      end
      StIdle: begin
        if (req_valid) begin
          ram_en_d   = 1'b1;
          ram_wea_d  = req_we;
          ram_addr_d = req_addr;
          if (req_we) begin
            ram_wr_data_d = req_wdata;
            state_d       = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StWr: begin
        wr_done_d = 1'b1;
        state_d   = StIdle;
      end
      StRd: begin
        lat_d   = LatLast;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (lat_q == 2'd0) begin
          rsp_rdata_d = ram_rd_data;
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state_q       <= StInit;
      cnt_q         <= '0;
      lat_q         <= '0;
      init_done_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      wr_done_q     <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_wea_q     <= 1'b0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lat_q         <= lat_d;
      init_done_q   <= init_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      wr_done_q     <= wr_done_d;
      ram_en_q      <= ram_en_d;
      ram_wea_q     <= ram_wea_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign wr_done     = wr_done_q;
  assign init_done   = init_done_q;
  assign ram_en      = ram_en_q;
  assign ram_wea     = ram_wea_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wr_data = ram_wr_data_q;

endmodule
